// File: rtl/ccip_mem_responder_pkg.sv
// Shared widths and bundle types for the CCI-P host-memory responder.
// Request bundles travel through the queues; tags through the pipes.
package ccip_mem_responder_pkg;

  localparam int LINE_W  = 512;
  localparam int ADDR_W  = 42;
  localparam int MDATA_W = 16;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [MDATA_W-1:0] mdata_t;

  typedef struct packed {
    addr_t  addr;
    mdata_t mdata;
  } rd_req_t;

  typedef struct packed {
    addr_t  addr;
    line_t  data;
    mdata_t mdata;
  } wr_req_t;

  typedef struct packed {
    logic   v;
    logic   oob;
    mdata_t mdata;
  } rsp_tag_t;

  // Offset of a line address from the window base (wraps mod 2^42).
  function automatic addr_t line_index(
    input addr_t a,
    input addr_t base
  );
    return a - base;
  endfunction

endpackage

// File: rtl/ccip_mem_responder_sync_req_fifo.sv
// Synchronous request queue with registered occupancy.
// Push is refused only when full; pop is ignored when empty.
module sync_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rp_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wp_d  = push_ok ? nxt(wp_q) : wp_q;
    rp_d  = pop_ok ? nxt(rp_q) : rp_q;
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ccip_mem_responder.sv
// CCI-P host-memory responder: queued c0 reads and c1 writes
// against a line RAM, answered LATENCY cycles after capture.
module ccip_mem_responder
  import ccip_mem_responder_pkg::*;
#(
  parameter int              DEPTH_LINES    = 1024,
  parameter longint unsigned BASE_LINE      = 0,
  parameter int              LATENCY        = 4,
  parameter int              FIFO_DEPTH     = 8,
  parameter int              ALMFULL_THRESH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req_valid,
  input  logic [ADDR_W-1:0]  rd_req_addr,
  input  logic [MDATA_W-1:0] rd_req_mdata,
  output logic               rd_rsp_valid,
  output logic [LINE_W-1:0]  rd_rsp_data,
  output logic [MDATA_W-1:0] rd_rsp_mdata,
  input  logic               wr_req_valid,
  input  logic [ADDR_W-1:0]  wr_req_addr,
  input  logic [LINE_W-1:0]  wr_req_data,
  input  logic [MDATA_W-1:0] wr_req_mdata,
  output logic               wr_ack_valid,
  output logic [MDATA_W-1:0] wr_ack_mdata,
  output logic               rd_almfull,
  output logic               wr_almfull,
  output logic               err_oob,
  output logic               err_ovf,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  localparam int NST = LATENCY - 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  =
    (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  rd_req_t  rd_in, rd_head;
  wr_req_t  wr_in, wr_head;
  logic     rd_push, rd_pop, rd_empty, rd_full;
  logic     wr_push, wr_pop, wr_empty, wr_full;
  logic [CW-1:0] rd_count, wr_count;
  addr_t    rd_idx, wr_idx;
  logic     rd_inb, wr_inb;

  line_t    ram [DEPTH_LINES] = '{default: '0};
  line_t    rdata_q;
  line_t    rd_tail_data;

  rsp_tag_t rp_q [NST];
  rsp_tag_t wp_q [NST];
  rsp_tag_t rd_tail, wr_tail;

  logic     rd_vld_q, wr_vld_q;
  line_t    rd_data_q;
  mdata_t   rd_md_q, wr_md_q;
  logic     err_oob_q, err_oob_d;
  logic     err_ovf_q, err_ovf_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  assign rd_in   = '{addr: rd_req_addr, mdata: rd_req_mdata};
  assign wr_in   = '{addr: wr_req_addr, data: wr_req_data,
                     mdata: wr_req_mdata};
  assign rd_push = rd_req_valid & ~reset;
  assign wr_push = wr_req_valid & ~reset;
  assign rd_pop  = ~rd_empty & ~reset;
  assign wr_pop  = ~wr_empty & ~reset;

  sync_req_fifo #(
    .W     ($bits(rd_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_push),
    .data_i  (rd_in),
    .pop_i   (rd_pop),
    .data_o  (rd_head),
    .empty_o (rd_empty),
    .full_o  (rd_full),
    .count_o (rd_count)
  );

  sync_req_fifo #(
    .W     ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_push),
    .data_i  (wr_in),
    .pop_i   (wr_pop),
    .data_o  (wr_head),
    .empty_o (wr_empty),
    .full_o  (wr_full),
    .count_o (wr_count)
  );

  assign rd_almfull =
    ~reset & (rd_count >= CW'(ALMFULL_THRESH));
  assign wr_almfull =
    ~reset & (wr_count >= CW'(ALMFULL_THRESH));

  assign rd_idx = line_index(rd_head.addr, addr_t'(BASE_LINE));
  assign wr_idx = line_index(wr_head.addr, addr_t'(BASE_LINE));
  assign rd_inb = rd_idx < addr_t'(DEPTH_LINES);
  assign wr_inb = wr_idx < addr_t'(DEPTH_LINES);

  // Simple dual-port RAM; a same-cycle read sees the old line.
  always_ff @(posedge clk) begin
    if (wr_pop && wr_inb)
      ram[wr_idx[IW-1:0]] <= wr_head.data;
    if (rd_pop && rd_inb)
      rdata_q <= ram[rd_idx[IW-1:0]];
  end

  // Read data trails the tag pipe; it needs no reset.
  if (NST > 1) begin : g_dpipe
    line_t dly_q [NST-1];
    // Shift read data alongside the tag pipe.
    always_ff @(posedge clk) begin
      dly_q[0] <= rdata_q;
      for (int i = 1; i < NST - 1; i++)
        dly_q[i] <= dly_q[i-1];
    end
    assign rd_tail_data = dly_q[NST-2];
  end else begin : g_nodpipe
    assign rd_tail_data = rdata_q;
  end

  // Valid/tag pipes, loaded on every pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NST; i++) begin
        rp_q[i] <= '0;
        wp_q[i] <= '0;
      end
    end else begin
      rp_q[0] <= '{v: rd_pop, oob: ~rd_inb,
                   mdata: rd_head.mdata};
      wp_q[0] <= '{v: wr_pop, oob: ~wr_inb,
                   mdata: wr_head.mdata};
      for (int i = 1; i < NST; i++) begin
        rp_q[i] <= rp_q[i-1];
        wp_q[i] <= wp_q[i-1];
      end
    end
  end

  assign rd_tail = rp_q[NST-1];
  assign wr_tail = wp_q[NST-1];

  // Sticky error flags and completion counters next-state.
  always_comb begin
    err_oob_d = err_oob_q
              | (rd_pop & ~rd_inb)
              | (wr_pop & ~wr_inb);
    err_ovf_d = err_ovf_q
              | (rd_req_valid & rd_full)
              | (wr_req_valid & wr_full);
    rd_cnt_d  = rd_cnt_q + 32'(rd_tail.v);
    wr_cnt_d  = wr_cnt_q + 32'(wr_tail.v);
  end

  // Response registers; payloads hold while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_md_q   <= '0;
      wr_md_q   <= '0;
      err_oob_q <= 1'b0;
      err_ovf_q <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      rd_vld_q  <= rd_tail.v;
      wr_vld_q  <= wr_tail.v;
      err_oob_q <= err_oob_d;
      err_ovf_q <= err_ovf_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      if (rd_tail.v) begin
        rd_data_q <= rd_tail.oob ? '0 : rd_tail_data;
        rd_md_q   <= rd_tail.mdata;
      end
      if (wr_tail.v) wr_md_q <= wr_tail.mdata;
    end
  end

  assign rd_rsp_valid = rd_vld_q;
  assign rd_rsp_data  = rd_data_q;
  assign rd_rsp_mdata = rd_md_q;
  assign wr_ack_valid = wr_vld_q;
  assign wr_ack_mdata = wr_md_q;
  assign err_oob      = err_oob_q;
  assign err_ovf      = err_ovf_q;
  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Directed bench for ccip_mem_responder: a vector table of single
// transactions plus sequences for ordering, overflow and reset.
module tb_ccip_mem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req_valid;
  logic [41:0]  rd_req_addr;
  logic [15:0]  rd_req_mdata;
  logic         rd_rsp_valid;
  logic [511:0] rd_rsp_data;
  logic [15:0]  rd_rsp_mdata;
  logic         wr_req_valid;
  logic [41:0]  wr_req_addr;
  logic [511:0] wr_req_data;
  logic [15:0]  wr_req_mdata;
  logic         wr_ack_valid;
  logic [15:0]  wr_ack_mdata;
  logic         rd_almfull;
  logic         wr_almfull;
  logic         err_oob;
  logic         err_ovf;
  logic [31:0]  rd_cnt;
  logic [31:0]  wr_cnt;

  int ntests = 0;
  int nfail  = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  typedef struct {
    bit           wr;
    logic [41:0]  addr;
    logic [511:0] data;
    logic [15:0]  mdata;
    logic [511:0] exp_data;
    bit           exp_oob;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  ccip_mem_responder #(
    .DEPTH_LINES    (1024),
    .BASE_LINE      (0),
    .LATENCY        (LAT),
    .FIFO_DEPTH     (8),
    .ALMFULL_THRESH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_mdata (rd_req_mdata),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_mdata (rd_rsp_mdata),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_mdata (wr_req_mdata),
    .wr_ack_valid (wr_ack_valid),
    .wr_ack_mdata (wr_ack_mdata),
    .rd_almfull   (rd_almfull),
    .wr_almfull   (wr_almfull),
    .err_oob      (err_oob),
    .err_ovf      (err_ovf),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt)
  );

  task automatic chk(
    input string        name,
    input logic [511:0] act,
    input logic [511:0] exp
  );
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    string        tag;
    logic [511:0] d;
    logic [15:0]  m;
    int           first;
    int           hits;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    if (v.wr) begin
      wr_req_valid = 1'b1;
      wr_req_addr  = v.addr;
      wr_req_data  = v.data;
      wr_req_mdata = v.mdata;
    end else begin
      rd_req_valid = 1'b1;
      rd_req_addr  = v.addr;
      rd_req_mdata = v.mdata;
    end
    @(posedge clk);
    #1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    first = -1;
    hits  = 0;
    d     = '0;
    m     = '0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (v.wr ? wr_ack_valid : rd_rsp_valid) begin
        if (first < 0) begin
          first = k;
          d = rd_rsp_data;
          m = v.wr ? wr_ack_mdata : rd_rsp_mdata;
        end
        hits++;
      end
    end
    if (v.wr) exp_wr++;
    else exp_rd++;
    chk({tag, ".latency"}, 512'(first), 512'(LAT));
    chk({tag, ".rsp_count"}, 512'(hits), 512'd1);
    chk({tag, ".mdata"}, 512'(m), 512'(v.mdata));
    if (!v.wr) begin
      chk({tag, ".data"}, d, v.exp_data);
      chk({tag, ".hold_data"}, rd_rsp_data, v.exp_data);
      chk({tag, ".hold_mdata"}, 512'(rd_rsp_mdata),
          512'(v.mdata));
    end
    chk({tag, ".err_oob"}, 512'(err_oob), 512'(v.exp_oob));
    chk({tag, ".cnt"}, 512'(v.wr ? wr_cnt : rd_cnt),
        512'(v.wr ? exp_wr : exp_rd));
  endtask

  // Reads issued while the read pop is held off, so the queue fills.
  task automatic stalled_reads(
    input int          n,
    input logic [15:0] mbase,
    input string       nm
  );
    logic [15:0] got [$];
    int          nacc;
    int          bad_data;
    nacc = (n < 8) ? n : 8;
    bad_data = 0;
    force dut.rd_pop = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_req_valid = 1'b1;
      rd_req_addr  = 42'h100 + 42'(i);
      rd_req_mdata = mbase + 16'(i);
      @(posedge clk);
      #1;
      rd_req_valid = 1'b0;
      chk($sformatf("%s.almfull%0d", nm, i),
          512'(rd_almfull),
          512'((((i + 1) < 8 ? (i + 1) : 8) >= 4)));
      chk($sformatf("%s.ovf%0d", nm, i),
          512'(err_ovf), 512'(i >= 8));
    end
    release dut.rd_pop;
    for (int k = 0; k < n + LAT + 6; k++) begin
      @(negedge clk);
      if (rd_rsp_valid) begin
        got.push_back(rd_rsp_mdata);
        if (rd_rsp_data !== '0) bad_data++;
      end
    end
    exp_rd += nacc;
    chk({nm, ".rsp_count"}, 512'(got.size()), 512'(nacc));
    for (int j = 0; j < got.size(); j++)
      chk($sformatf("%s.order%0d", nm, j),
          512'(got[j]), 512'(mbase + 16'(j)));
    chk({nm, ".data_zero"}, 512'(bad_data), 512'd0);
    chk({nm, ".rd_cnt"}, 512'(rd_cnt), 512'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           rf, wf, hits;
    logic [511:0] rd_d;
    logic [15:0]  rd_m, wr_m;
    vec_t         v;

    tbl[0]  = '{1'b1, 42'h10, 512'hDEADBEEF, 16'h0001,
                '0, 1'b0};
    tbl[1]  = '{1'b0, 42'h10, '0, 16'h0002,
                512'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 42'h3FF, 512'h1234, 16'h0003,
                '0, 1'b0};
    tbl[3]  = '{1'b0, 42'h3FF, '0, 16'h0004,
                512'h1234, 1'b0};
    tbl[4]  = '{1'b0, 42'h11, '0, 16'h0005, '0, 1'b0};
    tbl[5]  = '{1'b0, 42'h400, '0, 16'h0006, '0, 1'b1};
    tbl[6]  = '{1'b1, 42'h400, 512'hBAD, 16'h0007,
                '0, 1'b1};
    tbl[7]  = '{1'b0, 42'h0, '0, 16'h0008, '0, 1'b1};
    tbl[8]  = '{1'b0, 42'h400, '0, 16'h0009, '0, 1'b1};
    tbl[9]  = '{1'b0, 42'h100_0000_0010, '0, 16'h000A,
                '0, 1'b1};
    tbl[10] = '{1'b1, 42'h0, '1, 16'hFFFF, '0, 1'b1};
    tbl[11] = '{1'b0, 42'h0, '0, 16'hABCD, '1, 1'b1};

    reset        = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    rd_req_mdata = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    wr_req_mdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rd_valid", 512'(rd_rsp_valid), 512'd0);
    chk("rst.wr_valid", 512'(wr_ack_valid), 512'd0);
    chk("rst.rd_almfull", 512'(rd_almfull), 512'd0);
    chk("rst.wr_almfull", 512'(wr_almfull), 512'd0);
    chk("rst.err_oob", 512'(err_oob), 512'd0);
    chk("rst.err_ovf", 512'(err_ovf), 512'd0);
    chk("rst.rd_cnt", 512'(rd_cnt), 512'd0);
    chk("rst.wr_cnt", 512'(wr_cnt), 512'd0);
    chk("rst.rd_data", rd_rsp_data, 512'd0);
    chk("rst.rd_mdata", 512'(rd_rsp_mdata), 512'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_row(tbl[i], i);

    // Read and write to the same line popped together.
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = 42'h20;
    rd_req_mdata = 16'h0032;
    wr_req_valid = 1'b1;
    wr_req_addr  = 42'h20;
    wr_req_data  = 512'h5A;
    wr_req_mdata = 16'h0031;
    @(posedge clk);
    #1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    rf = -1;
    wf = -1;
    rd_d = '1;
    rd_m = '0;
    wr_m = '0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (rd_rsp_valid && rf < 0) begin
        rf = k;
        rd_d = rd_rsp_data;
        rd_m = rd_rsp_mdata;
      end
      if (wr_ack_valid && wf < 0) begin
        wf = k;
        wr_m = wr_ack_mdata;
      end
    end
    exp_rd++;
    exp_wr++;
    chk("rbw.rd_latency", 512'(rf), 512'(LAT));
    chk("rbw.wr_latency", 512'(wf), 512'(LAT));
    chk("rbw.old_data", rd_d, 512'd0);
    chk("rbw.rd_mdata", 512'(rd_m), 512'h32);
    chk("rbw.wr_mdata", 512'(wr_m), 512'h31);
    v = '{1'b0, 42'h20, '0, 16'h0033, 512'h5A, 1'b1};
    run_row(v, 100);

    stalled_reads(8, 16'h0000, "burst8");
    chk("burst8.no_ovf", 512'(err_ovf), 512'd0);
    stalled_reads(9, 16'h0100, "burst9");
    chk("burst9.ovf_sticky", 512'(err_ovf), 512'd1);

    // Reset arriving with reads in flight.
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = 42'h10;
    rd_req_mdata = 16'h0200;
    @(posedge clk);
    #1;
    rd_req_mdata = 16'h0201;
    @(posedge clk);
    #1;
    rd_req_mdata = 16'h0202;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_req_valid = 1'b0;
    hits = 0;
    for (int k = 0; k < 2 * LAT + 6; k++) begin
      @(negedge clk);
      if (rd_rsp_valid) hits++;
    end
    exp_rd = 0;
    exp_wr = 0;
    chk("midrst.no_rsp", 512'(hits), 512'd0);
    chk("midrst.rd_cnt", 512'(rd_cnt), 512'd0);
    chk("midrst.wr_cnt", 512'(wr_cnt), 512'd0);
    chk("midrst.err_oob", 512'(err_oob), 512'd0);
    chk("midrst.err_ovf", 512'(err_ovf), 512'd0);
    chk("midrst.rd_almfull", 512'(rd_almfull), 512'd0);
    chk("midrst.wr_almfull", 512'(wr_almfull), 512'd0);
    chk("midrst.rd_data", rd_rsp_data, 512'd0);
    chk("midrst.rd_mdata", 512'(rd_rsp_mdata), 512'd0);

    // Memory survives reset.
    v = '{1'b0, 42'h10, '0, 16'h0300, 512'hDEADBEEF, 1'b0};
    run_row(v, 200);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
